// File: rtl/pc_sequencer.sv
// Program counter with reset vector, stall, branch redirect and call/return
// through a circular return-address stack; all outputs registered.
module pc_sequencer #(
    parameter int unsigned     WIDTH     = 64,
    parameter int unsigned     INC       = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic                             branch_taken,
    input  logic [WIDTH-1:0]                 branch_target,
    input  logic                             call,
    input  logic [WIDTH-1:0]                 call_target,
    input  logic                             ret,
    output logic [WIDTH-1:0]                 pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_overflow,
    output logic                             ret_fault
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0] top;

    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] seq_pc;
    logic [PTR_W-1:0] next_top;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic [CNT_W-1:0] next_count;
    logic             next_overflow;
    logic             next_fault;
    logic             push;
    logic             full;

    assign seq_pc  = pc + WIDTH'(INC);
    assign full    = (ras_count == CNT_W'(RAS_DEPTH));
    // Explicit wrap keeps the pointer correct for non-power-of-two depths
    assign top_inc = (top == PTR_W'(RAS_DEPTH - 1)) ? '0 : top + PTR_W'(1);
    assign top_dec = (top == '0) ? PTR_W'(RAS_DEPTH - 1) : top - PTR_W'(1);

    // Next-state decode: stall > branch > call > ret > sequential
    always_comb begin
        next_pc       = pc;
        next_top      = top;
        next_count    = ras_count;
        next_overflow = 1'b0;
        next_fault    = 1'b0;
        push          = 1'b0;
        if (stall) begin
            next_pc = pc;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else if (call) begin
            push     = 1'b1;
            next_top = top_inc;
            next_pc  = call_target;
            if (full) begin
                next_overflow = 1'b1;
            end else begin
                next_count = ras_count + CNT_W'(1);
            end
        end else if (ret) begin
            if (ras_count != '0) begin
                next_top   = top_dec;
                next_pc    = ras[top_dec];
                next_count = ras_count - CNT_W'(1);
            end else begin
                next_pc    = seq_pc;
                next_fault = 1'b1;
            end
        end else begin
            next_pc = seq_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_VEC;
            top          <= '0;
            ras_count    <= '0;
            ras_overflow <= 1'b0;
            ret_fault    <= 1'b0;
        end else begin
            pc           <= next_pc;
            top          <= next_top;
            ras_count    <= next_count;
            ras_overflow <= next_overflow;
            ret_fault    <= next_fault;
        end
    end

    // Stack storage has no reset; a call coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ras[top] <= seq_pc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference stack predicts
// each cycle's outputs; a monitor compares them one cycle after the edge.
module tb_pc_sequencer;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] cnt;
        logic        ovf;
        logic        flt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = '0;
    logic        call = 1'b0;
    logic [63:0] call_target = '0;
    logic        ret = 1'b0;
    logic [63:0] pc;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ret_fault;

    int checks = 0;
    int failures = 0;

    logic [63:0] m_pc = '0;
    logic [63:0] m_stk [$];
    exp_t        sb [$];

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .call          (call),
        .call_target   (call_target),
        .ret           (ret),
        .pc            (pc),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ret_fault     (ret_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of controls, predict the result, wait until after the edge
    task automatic cycle(input logic r, input logic s, input logic b, input logic [63:0] bt,
                         input logic c, input logic [63:0] ct, input logic rt);
        exp_t e;
        rst = r; stall = s; branch_taken = b; branch_target = bt;
        call = c; call_target = ct; ret = rt;
        e.ovf = 1'b0;
        e.flt = 1'b0;
        if (r) begin
            m_pc = '0;
            m_stk.delete();
        end else if (s) begin
            m_pc = m_pc;
        end else if (b) begin
            m_pc = bt;
        end else if (c) begin
            if (m_stk.size() == 4) begin
                void'(m_stk.pop_front());
                e.ovf = 1'b1;
            end
            m_stk.push_back(m_pc + 64'd4);
            m_pc = ct;
        end else if (rt) begin
            if (m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
            end else begin
                m_pc = m_pc + 64'd4;
                e.flt = 1'b1;
            end
        end else begin
            m_pc = m_pc + 64'd4;
        end
        e.pc  = m_pc;
        e.cnt = 64'(m_stk.size());
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, '0, 0, '0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, '0, 0, '0, 0);
    endtask

    // Monitor: compare outputs against the oldest prediction after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc",  pc, e.pc);
                check("cnt", 64'(ras_count), e.cnt);
                check("ovf", 64'(ras_overflow), 64'(e.ovf));
                check("flt", 64'(ret_fault), 64'(e.flt));
            end
        end
    end

    initial begin
        // Reset then idle counting
        do_reset();
        check("rst_pc", pc, 64'h0);
        idle(); check("seq4", pc, 64'h4);
        idle(); check("seq8", pc, 64'h8);
        // Stall dominates branch
        cycle(0, 1, 1, 64'h100, 0, '0, 0); check("stall1", pc, 64'h8);
        cycle(0, 1, 1, 64'h100, 0, '0, 0); check("stall2", pc, 64'h8);
        idle(); check("post_stall", pc, 64'hC);
        idle(); check("pc10", pc, 64'h10);
        // Call / return round trip
        cycle(0, 0, 0, '0, 1, 64'h200, 0); check("call_pc", pc, 64'h200);
        check("call_cnt", 64'(ras_count), 64'd1);
        idle(); check("pc204", pc, 64'h204);
        cycle(0, 0, 0, '0, 0, '0, 1); check("ret_pc", pc, 64'h14);
        check("ret_cnt", 64'(ras_count), 64'd0);

        // Overflow then underflow
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(0, 0, 0, '0, 1, 64'(i) << 8, 0);
        check("ovf_pulse", 64'(ras_overflow), 64'd1);
        check("ovf_cnt", 64'(ras_count), 64'd4);
        cycle(0, 0, 0, '0, 0, '0, 1); check("ret1", pc, 64'h404);
        check("ovf_clear", 64'(ras_overflow), 64'd0);
        cycle(0, 0, 0, '0, 0, '0, 1); check("ret2", pc, 64'h304);
        cycle(0, 0, 0, '0, 0, '0, 1); check("ret3", pc, 64'h204);
        cycle(0, 0, 0, '0, 0, '0, 1); check("ret4", pc, 64'h104);
        cycle(0, 0, 0, '0, 0, '0, 1); check("ret5_pc", pc, 64'h108);
        check("ret_fault", 64'(ret_fault), 64'd1);
        idle(); check("fault_clear", 64'(ret_fault), 64'd0);

        // Branch beats simultaneous call and ret
        cycle(0, 0, 0, '0, 1, 64'h40, 0);
        cycle(0, 0, 1, 64'h80, 1, 64'h300, 1); check("prio_pc", pc, 64'h80);
        check("prio_cnt", 64'(ras_count), 64'd1);

        // Wrap-around, then reset swallows a call
        cycle(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, '0, 0);
        idle(); check("wrap", pc, 64'h0);
        cycle(1, 0, 0, '0, 1, 64'h300, 0); check("rst_call_pc", pc, 64'h0);
        check("rst_call_cnt", 64'(ras_count), 64'd0);

        // Random traffic against the reference stack
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 60) == 0, ($urandom % 6) == 0, ($urandom % 5) == 0,
                  {$urandom, $urandom} & ~64'h3, ($urandom % 3) == 0,
                  {$urandom, $urandom} & ~64'h3, ($urandom % 3) == 0);
        end

        @(posedge clk);
        #2;
        if (sb.size() != 0) check("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
